// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of every handshake/bus signal around mem_port_arbiter.
//   Requester side (2 requesters, packed, requester i in slice i):
//     req_valid/req_ready/req_wen/req_addr/req_len   burst request
//     wdata/wdata_valid/wdata_ready                  write beats
//     rdata/rdata_valid/rdata_last/rdata_ready       read beats (rdata broadcast)
//     wresp_valid                                    write completion pulse
//   Memory side (single downstream port):
//     mem_req_*, mem_wdata_*, mem_rdata_*, mem_wresp_*
// Modports:
//   master : the arbiter itself (drives the shared memory port)
//   slave  : the surroundings (both requesters plus the memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_wen;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*LEN_W-1:0]  req_len;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          wdata_valid;
    logic [1:0]          wdata_ready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rdata_valid;
    logic                rdata_last;
    logic [1:0]          rdata_ready;
    logic [1:0]          wresp_valid;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_wen;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [LEN_W-1:0]    mem_req_len;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_wdata_valid;
    logic                mem_wdata_last;
    logic                mem_wdata_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rdata_valid;
    logic                mem_rdata_last;
    logic                mem_rdata_ready;
    logic                mem_wresp_valid;
    logic                mem_wresp_ready;

    modport master (
        input  req_valid, req_wen, req_addr, req_len, wdata, wdata_valid, rdata_ready,
        output req_ready, wdata_ready, rdata, rdata_valid, rdata_last, wresp_valid,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_len,
        input  mem_req_ready,
        output mem_wdata, mem_wdata_valid, mem_wdata_last,
        input  mem_wdata_ready,
        input  mem_rdata, mem_rdata_valid, mem_rdata_last,
        output mem_rdata_ready,
        input  mem_wresp_valid,
        output mem_wresp_ready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_len, wdata, wdata_valid, rdata_ready,
        input  req_ready, wdata_ready, rdata, rdata_valid, rdata_last, wresp_valid,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_len,
        output mem_req_ready,
        input  mem_wdata, mem_wdata_valid, mem_wdata_last,
        output mem_wdata_ready,
        output mem_rdata, mem_rdata_valid, mem_rdata_last,
        input  mem_rdata_ready,
        output mem_wresp_valid,
        input  mem_wresp_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory master port between requester 0 (icache) and requester 1
// (dcache). Whole bursts are arbitrated: request, all data beats, then (for
// writes) the write response. Bursts never overlap or interleave.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; abandons any burst in flight
//   bus   mem_port_arbiter_if.master, requester and memory handshakes
//   busy  high whenever the arbiter is not idle
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   : simultaneous requests alternate (~last_gnt)
//                       undefined : fixed priority, requester 1 always wins
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, REQ, RDATA, WDATA, WRESP} state_t;

    state_t             state_reg, state_next;
    logic               gnt_reg, gnt_next;
    logic               wen_reg, wen_next;
    logic               last_gnt_reg, last_gnt_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               winner;
    logic               wr_last;

    logic [ADDR_W-1:0]  addr_arr  [2];
    logic [LEN_W-1:0]   len_arr   [2];
    logic [DATA_W-1:0]  wdata_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign len_arr[gi]   = bus.req_len[gi*LEN_W +: LEN_W];
        assign wdata_arr[gi] = bus.wdata[gi*DATA_W +: DATA_W];
    end

    // Grant selection, only consulted in IDLE.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (&bus.req_valid) winner = ~last_gnt_reg;
        else                winner = bus.req_valid[1];
`else
        winner = bus.req_valid[1];
`endif
    end

    assign wr_last = (beat_cnt_reg == len_reg);
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= 1'b0;
            wen_reg      <= 1'b0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            last_gnt_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            wen_reg      <= wen_next;
            len_reg      <= len_next;
            beat_cnt_reg <= beat_cnt_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        wen_next      = wen_reg;
        len_next      = len_reg;
        beat_cnt_next = beat_cnt_reg;
        last_gnt_next = last_gnt_reg;

        bus.req_ready       = '0;
        bus.wdata_ready     = '0;
        bus.rdata_valid     = '0;
        bus.rdata_last      = 1'b0;
        bus.wresp_valid     = '0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_wdata_valid = 1'b0;
        bus.mem_wdata_last  = 1'b0;
        bus.mem_rdata_ready = 1'b0;
        bus.mem_wresp_ready = 1'b0;

        // Payload buses follow the granted requester; only valids are gated.
        bus.mem_req_wen  = bus.req_wen[gnt_reg];
        bus.mem_req_addr = addr_arr[gnt_reg];
        bus.mem_req_len  = len_arr[gnt_reg];
        bus.mem_wdata    = wdata_arr[gnt_reg];
        bus.rdata        = bus.mem_rdata;

        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    gnt_next      = winner;
                    wen_next      = bus.req_wen[winner];
                    len_next      = len_arr[winner];
                    beat_cnt_next = '0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                bus.mem_req_valid      = 1'b1;
                bus.req_ready[gnt_reg] = bus.mem_req_ready;
                if (bus.mem_req_ready) state_next = wen_reg ? WDATA : RDATA;
            end
            RDATA: begin
                // Burst end is decided by the memory's last flag, not counted.
                bus.rdata_valid[gnt_reg] = bus.mem_rdata_valid;
                bus.rdata_last           = bus.mem_rdata_last;
                bus.mem_rdata_ready      = bus.rdata_ready[gnt_reg];
                if (bus.mem_rdata_valid && bus.rdata_ready[gnt_reg] && bus.mem_rdata_last) begin
                    last_gnt_next = gnt_reg;
                    state_next    = IDLE;
                end
            end
            WDATA: begin
                bus.mem_wdata_valid      = bus.wdata_valid[gnt_reg];
                bus.mem_wdata_last       = wr_last;
                bus.wdata_ready[gnt_reg] = bus.mem_wdata_ready;
                if (bus.wdata_valid[gnt_reg] && bus.mem_wdata_ready) begin
                    // Hold the counter on the final beat so len=max never wraps.
                    if (wr_last) state_next    = WRESP;
                    else         beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            WRESP: begin
                bus.mem_wresp_ready = 1'b1;
                if (bus.mem_wresp_valid) begin
                    bus.wresp_valid[gnt_reg] = 1'b1;
                    last_gnt_next            = gnt_reg;
                    state_next               = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench: a table of single-burst transactions with hand-computed
// expectations, followed by hand-written sequences for arbitration latency,
// contention and reset in the middle of a write burst.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

`ifdef ARB_ROUND_ROBIN_EN
    localparam int FIRST = 0;
`else
    localparam int FIRST = 1;
`endif

    int passed = 0;
    int total  = 0;

    // Per-transaction observation counters.
    int beats, last_cnt, data_err, leak, addr_bad, pulses, wresp_err;
    logic [31:0] last_data;

    typedef struct {
        bit          wen;
        int          r;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        logic [31:0] dstep;
        int          stall;
        bit          toggle;
        int          exp_beats;
        logic [31:0] exp_last;
        string       tag;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        else passed++;
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.rdata_last,
                    bus.wresp_valid, bus.mem_req_valid, bus.mem_wdata_valid,
                    bus.mem_rdata_ready, bus.mem_wresp_ready, busy});
    endfunction

    task automatic idle_inputs();
        bus.req_valid = '0;  bus.req_wen = '0;  bus.req_addr = '0;  bus.req_len = '0;
        bus.wdata = '0;  bus.wdata_valid = '0;  bus.rdata_ready = '0;
        bus.mem_req_ready = 1'b0;  bus.mem_wdata_ready = 1'b0;
        bus.mem_rdata = '0;  bus.mem_rdata_valid = 1'b0;  bus.mem_rdata_last = 1'b0;
        bus.mem_wresp_valid = 1'b0;
    endtask

    task automatic clear_counters();
        beats = 0; last_cnt = 0; data_err = 0; leak = 0; addr_bad = 0;
        pulses = 0; wresp_err = 0; last_data = '0;
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the request handshake.
    task automatic req_phase(input int r, input logic wen, input logic [31:0] addr,
                             input logic [7:0] len, input int stall, input string tag);
        int  o, cyc, seen;
        bit  done;
        o = 1 - r; cyc = 0; seen = 0; done = 1'b0;
        bus.req_valid[r] = 1'b1;
        bus.req_wen[r]   = wen;
        bus.req_addr[r*32 +: 32] = addr;
        bus.req_len[r*8 +: 8]    = len;
        while (!done && cyc < 100) begin
            #1;
            if (bus.mem_req_valid) begin
                if (bus.mem_req_addr !== addr || bus.mem_req_wen !== wen || bus.mem_req_len !== len)
                    addr_bad++;
                if (seen >= stall) bus.mem_req_ready = 1'b1;
                seen++;
                #1;
                if (bus.req_ready[r] && bus.mem_req_ready) done = 1'b1;
            end
            if (bus.req_ready[o] !== 1'b0) leak++;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            cyc++;
        end
        bus.req_valid[r] = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL %s_req: got no req_ready handshake in %0d cycles, required one", tag, cyc);
        end
    endtask

    task automatic do_read(input int r, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] d0, input logic [31:0] dstep, input int stall,
                           input bit toggle, input int exp_beats, input logic [31:0] exp_last,
                           input string tag);
        int o, k, cyc;
        o = 1 - r; k = 0; cyc = 0;
        clear_counters();
        req_phase(r, 1'b0, addr, len, stall, tag);
        while (k <= int'(len) && cyc < 1200) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = d0 + 32'(k) * dstep;
            bus.mem_rdata_last  = (k == int'(len));
            bus.rdata_ready[r]  = toggle ? cyc[0] : 1'b1;
            #1;
            if (bus.rdata !== bus.mem_rdata) data_err++;
            if (bus.mem_rdata_ready !== bus.rdata_ready[r]) data_err++;
            if (bus.rdata_valid[o] !== 1'b0) leak++;
            if (bus.rdata_valid[r] && bus.rdata_ready[r]) begin
                beats++;
                if (bus.rdata_last) begin last_cnt++; last_data = bus.rdata; end
            end
            if (bus.mem_rdata_ready) k++;
            @(negedge clk);
            cyc++;
        end
        if (k <= int'(len)) begin
            total++;
            $display("FAIL %s_rdata: got %0d memory beats taken, required %0d", tag, k, int'(len) + 1);
        end
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata_last  = 1'b0;
        bus.rdata_ready[r]  = 1'b0;
        #1;
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_beats"}, 64'(beats), 64'(exp_beats));
        check({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
        check({tag, "_last_data"}, 64'(last_data), 64'(exp_last));
        check({tag, "_data_err"}, 64'(data_err), 64'd0);
        check({tag, "_other_leak"}, 64'(leak), 64'd0);
        check({tag, "_req_payload"}, 64'(addr_bad), 64'd0);
    endtask

    // abort >= 0 stops after that many accepted beats and leaves the burst open.
    task automatic do_write(input int r, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] d0, input logic [31:0] dstep, input int stall,
                            input bit toggle, input int abort, input int exp_beats,
                            input logic [31:0] exp_last, input string tag);
        int o, k, cyc;
        logic [1:0] exp_w;
        o = 1 - r; k = 0; cyc = 0;
        exp_w = (r == 1) ? 2'b10 : 2'b01;
        clear_counters();
        req_phase(r, 1'b1, addr, len, stall, tag);
        while (k <= int'(len) && cyc < 1200 && (abort < 0 || k < abort)) begin
            bus.wdata[r*32 +: 32] = d0 + 32'(k) * dstep;
            bus.wdata_valid[r]    = 1'b1;
            bus.mem_wdata_ready   = toggle ? cyc[0] : 1'b1;
            #1;
            if (bus.mem_wdata_valid !== 1'b1 || bus.mem_wdata !== d0 + 32'(k) * dstep) data_err++;
            if (bus.wdata_ready[r] !== bus.mem_wdata_ready) data_err++;
            if (bus.wdata_ready[o] !== 1'b0) leak++;
            if (bus.mem_wdata_valid && bus.mem_wdata_ready) begin
                beats++;
                if (bus.mem_wdata_last) begin last_cnt++; last_data = bus.mem_wdata; end
            end
            if (bus.wdata_valid[r] && bus.wdata_ready[r]) k++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1200) begin
            total++;
            $display("FAIL %s_wdata: got %0d beats accepted, required %0d", tag, k, int'(len) + 1);
        end
        if (abort >= 0) begin
            check({tag, "_beats_before_abort"}, 64'(beats), 64'(exp_beats));
            check({tag, "_no_early_last"}, 64'(last_cnt), 64'd0);
        end else begin
            bus.wdata_valid[r]  = 1'b0;
            bus.mem_wdata_ready = 1'b0;
            repeat (2) begin
                #1;
                if (bus.mem_wresp_ready !== 1'b1) wresp_err++;
                if (bus.wresp_valid !== 2'b00) wresp_err++;
                @(negedge clk);
            end
            bus.mem_wresp_valid = 1'b1;
            #1;
            if (bus.wresp_valid === exp_w) pulses++;
            else wresp_err++;
            @(negedge clk);
            bus.mem_wresp_valid = 1'b0;
            #1;
            if (bus.wresp_valid !== 2'b00) wresp_err++;
            check({tag, "_busy_drop"}, 64'(busy), 64'd0);
            check({tag, "_beats"}, 64'(beats), 64'(exp_beats));
            check({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
            check({tag, "_last_data"}, 64'(last_data), 64'(exp_last));
            check({tag, "_data_err"}, 64'(data_err), 64'd0);
            check({tag, "_other_leak"}, 64'(leak), 64'd0);
            check({tag, "_req_payload"}, 64'(addr_bad), 64'd0);
            check({tag, "_wresp_pulses"}, 64'(pulses), 64'd1);
            check({tag, "_wresp_err"}, 64'(wresp_err), 64'd0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //           wen r  addr      len   d0            dstep   stall tog beats last
        vecs[0] = '{1'b0, 0, 32'h100, 8'd3,   32'hA0,       32'h1,  0, 1'b0, 4,   32'hA3,       "rd_single"};
        vecs[1] = '{1'b1, 1, 32'h200, 8'd1,   32'h11,       32'h11, 0, 1'b0, 2,   32'h22,       "wr_single"};
        vecs[2] = '{1'b1, 0, 32'h240, 8'd0,   32'hDEADBEEF, 32'h0,  0, 1'b0, 1,   32'hDEADBEEF, "wr_len0"};
        vecs[3] = '{1'b0, 0, 32'h100, 8'd3,   32'hA0,       32'h1,  5, 1'b1, 4,   32'hA3,       "rd_backpressure"};
        vecs[4] = '{1'b0, 1, 32'h400, 8'd0,   32'h55,       32'h0,  0, 1'b0, 1,   32'h55,       "rd_len0"};
        vecs[5] = '{1'b1, 1, 32'h800, 8'd255, 32'h0,        32'h1,  2, 1'b1, 256, 32'hFF,       "wr_len255"};

        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outputs", out_vec(), 64'd0);
        @(negedge clk);

        // Arbitration latency: mem_req_valid one cycle after req_valid.
        bus.req_valid[0] = 1'b1;
        bus.req_addr[31:0] = 32'h100;
        bus.req_len[7:0]   = 8'd0;
        #1;
        check("latency_idle_cycle", 64'(bus.mem_req_valid), 64'd0);
        @(negedge clk);
        #1;
        check("latency_req_cycle", 64'(bus.mem_req_valid), 64'd1);
        check("latency_busy", 64'(busy), 64'd1);
        do_read(0, 32'h100, 8'd0, 32'h77, 32'h0, 0, 1'b0, 1, 32'h77, "rd_latency");

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vecs[i].wen)
                do_write(vecs[i].r, vecs[i].addr, vecs[i].len, vecs[i].d0, vecs[i].dstep,
                         vecs[i].stall, vecs[i].toggle, -1, vecs[i].exp_beats, vecs[i].exp_last,
                         vecs[i].tag);
            else
                do_read(vecs[i].r, vecs[i].addr, vecs[i].len, vecs[i].d0, vecs[i].dstep,
                        vecs[i].stall, vecs[i].toggle, vecs[i].exp_beats, vecs[i].exp_last,
                        vecs[i].tag);
            $display("vector %0d %s done: beats=%0d last_data=0x%0h", i, vecs[i].tag, beats, last_data);
        end

        // Contention straight after reset (last_gnt = 1).
        apply_reset();
        bus.req_valid = 2'b11;
        bus.req_wen   = 2'b00;
        bus.req_addr  = {32'h200, 32'h100};
        bus.req_len   = {8'd0, 8'd0};
        #1;
        check("contention_idle_cycle", 64'(bus.mem_req_valid), 64'd0);
        @(negedge clk);
        #1;
        check("contention_first_addr", 64'(bus.mem_req_addr), (FIRST == 0) ? 64'h100 : 64'h200);
        if (FIRST == 0) begin
            do_read(0, 32'h100, 8'd0, 32'hB0, 32'h0, 0, 1'b0, 1, 32'hB0, "cont_first_r0");
            do_read(1, 32'h200, 8'd0, 32'hC0, 32'h0, 0, 1'b0, 1, 32'hC0, "cont_second_r1");
        end else begin
            do_read(1, 32'h200, 8'd0, 32'hC0, 32'h0, 0, 1'b0, 1, 32'hC0, "cont_first_r1");
            do_read(0, 32'h100, 8'd0, 32'hB0, 32'h0, 0, 1'b0, 1, 32'hB0, "cont_second_r0");
        end
        $display("contention done: first granted requester %0d", FIRST);

        // Reset after 2 of 4 write beats; write data stays offered.
        @(negedge clk);
        do_write(1, 32'h200, 8'd3, 32'h10, 32'h1, 0, 1'b0, 2, 2, 32'h0, "wr_abort");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_outputs_cleared", out_vec(), 64'd0);
        @(negedge clk);
        #1;
        check("abort_no_more_beats", 64'(bus.mem_wdata_valid), 64'd0);
        bus.wdata_valid     = '0;
        bus.mem_wdata_ready = 1'b0;
        @(negedge clk);
        do_read(0, 32'h300, 8'd2, 32'hE0, 32'h1, 0, 1'b0, 3, 32'hE2, "rd_after_abort");
        $display("reset mid-write sequence done");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
